// File: rtl/fcl1_pkg.sv
// fcl1_pkg: shared defaults and FSM state type for the fcl1 accumulate/ReLU stage
package fcl1_pkg;
  localparam int FCL_DATA_W           = 8;
  localparam int FCL_ACC_W            = 24;
  localparam int FCL_WORDS_PER_NEURON = 5;
  localparam int FCL_NUM_NEURONS      = 120;
  localparam int FCL_SHIFT            = 4;
  localparam int FCL_IDX_W            = 7;
  typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_FLUSH, ST_DONE} fcl_state_e;
endpackage

// File: rtl/fcl1_acc_relu_if.sv
// fcl1_acc_relu_if: result valid/ready channel carrying ReLU output and neuron index
interface fcl1_acc_relu_if import fcl1_pkg::*; #(parameter int DATA_W = FCL_DATA_W) ();
  logic                       fcl_acc_out_valid_o;
  logic                       fcl_acc_out_ready_i;
  logic signed [DATA_W-1:0]   fcl_acc_out_data_o;
  logic [FCL_IDX_W-1:0]       fcl_acc_out_idx_o;
  modport master (output fcl_acc_out_valid_o, fcl_acc_out_data_o, fcl_acc_out_idx_o, input fcl_acc_out_ready_i);
  modport slave  (input fcl_acc_out_valid_o, fcl_acc_out_data_o, fcl_acc_out_idx_o, output fcl_acc_out_ready_i);
endinterface

// File: rtl/fcl1_res_fifo.sv
// fcl1_res_fifo: 2-entry result FIFO; a push into a full FIFO is accepted only alongside a pop
module fcl1_res_fifo #(parameter int W = 15) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);
  logic [W-1:0] r_mem [2];
  logic         r_wp, r_rp;
  logic [1:0]   r_cnt;
  logic         w_push, w_pop;
  assign o_empty = r_cnt == 2'd0;
  assign o_full  = r_cnt == 2'd2;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dout  = r_mem[r_rp];
  // storage, pointers and occupancy; clear empties the FIFO and zeroes the head
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n || i_clr) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
endmodule

// File: rtl/fcl1_acc_relu.sv
// fcl1_acc_relu: per-neuron MAC with bias, arithmetic shift, ReLU clamp and buffered result output
module fcl1_acc_relu import fcl1_pkg::*; #(
  parameter int DATA_W           = FCL_DATA_W,
  parameter int ACC_W            = FCL_ACC_W,
  parameter int WORDS_PER_NEURON = FCL_WORDS_PER_NEURON,
  parameter int NUM_NEURONS      = FCL_NUM_NEURONS,
  parameter int SHIFT            = FCL_SHIFT
) (
  input  logic                       fcl_acc_clk,
  input  logic                       fcl_acc_rst_b,
  input  logic                       fcl_acc_start_i,
  input  logic                       fcl_acc_restart_i,
  input  logic                       fcl_acc_sram_rd_en_i,
  input  logic signed [DATA_W-1:0]   fcl_acc_wt_i,
  input  logic signed [DATA_W-1:0]   fcl_acc_act_i,
  input  logic signed [2*DATA_W-1:0] fcl_acc_bias_i,
  fcl1_acc_relu_if.master            out_if,
  output logic                       fcl_acc_done_o,
  output logic                       fcl_acc_ovf_o
);
  localparam int WC_W = $clog2(WORDS_PER_NEURON + 1);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (DATA_W - 1)) - 1);
  fcl_state_e                 r_state, w_state_nx;
  logic                       r_smp_v, r_ovf;
  logic [WC_W-1:0]            r_wcnt;
  logic [FCL_IDX_W-1:0]       r_ncnt;
  logic signed [ACC_W-1:0]    r_acc, w_acc_nx, w_res;
  logic signed [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]          w_relu;
  logic [DATA_W+FCL_IDX_W-1:0] w_dout;
  logic                       w_smp, w_last, w_push, w_empty, w_full, w_pop;
  assign w_prod   = (2*DATA_W)'(fcl_acc_wt_i) * (2*DATA_W)'(fcl_acc_act_i);
  assign w_smp    = r_smp_v && r_state == ST_ACC && !fcl_acc_restart_i;
  assign w_last   = r_wcnt == WC_W'(WORDS_PER_NEURON - 1);
  assign w_push   = w_smp && w_last;
  assign w_acc_nx = (r_wcnt == '0 ? ACC_W'(fcl_acc_bias_i) : r_acc) + ACC_W'(w_prod);
  assign w_res    = w_acc_nx >>> SHIFT;
  assign w_relu   = w_res[ACC_W-1] ? '0 : (w_res > MAXV ? MAXV[DATA_W-1:0] : w_res[DATA_W-1:0]);
  assign w_pop    = out_if.fcl_acc_out_ready_i;
  assign out_if.fcl_acc_out_valid_o = !w_empty;
  assign {out_if.fcl_acc_out_data_o, out_if.fcl_acc_out_idx_o} = w_dout;
  assign fcl_acc_done_o = r_state == ST_DONE;
  assign fcl_acc_ovf_o  = r_ovf;
  // SRAM read data arrives one cycle after the strobe
  always_ff @(posedge fcl_acc_clk or negedge fcl_acc_rst_b)
    if (!fcl_acc_rst_b) r_smp_v <= 1'b0;
    else r_smp_v <= fcl_acc_sram_rd_en_i;
  // state register
  always_ff @(posedge fcl_acc_clk or negedge fcl_acc_rst_b)
    if (!fcl_acc_rst_b) r_state <= ST_IDLE;
    else r_state <= w_state_nx;
  // next state; restart wins over everything
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  w_state_nx = fcl_acc_start_i ? ST_ACC : ST_IDLE;
      ST_ACC:   w_state_nx = (w_push && r_ncnt == FCL_IDX_W'(NUM_NEURONS - 1)) ? ST_FLUSH : ST_ACC;
      ST_FLUSH: w_state_nx = w_empty ? ST_DONE : ST_FLUSH;
      default:  w_state_nx = ST_IDLE;
    endcase
    if (fcl_acc_restart_i) w_state_nx = ST_IDLE;
  end
  // word/neuron counters and accumulator
  always_ff @(posedge fcl_acc_clk or negedge fcl_acc_rst_b)
    if (!fcl_acc_rst_b || fcl_acc_restart_i) begin
      r_wcnt <= '0;
      r_ncnt <= '0;
      r_acc  <= '0;
    end else if (w_smp) begin
      r_acc  <= w_acc_nx;
      r_wcnt <= w_last ? '0 : r_wcnt + WC_W'(1);
      if (w_last) r_ncnt <= r_ncnt == FCL_IDX_W'(NUM_NEURONS - 1) ? '0 : r_ncnt + FCL_IDX_W'(1);
    end
  // sticky overflow: set on a dropped result, cleared by an accepted start
  always_ff @(posedge fcl_acc_clk or negedge fcl_acc_rst_b)
    if (!fcl_acc_rst_b) r_ovf <= 1'b0;
    else if (r_state == ST_IDLE && fcl_acc_start_i && !fcl_acc_restart_i) r_ovf <= 1'b0;
    else if (w_push && w_full && !(w_pop && !w_empty)) r_ovf <= 1'b1;
  fcl1_res_fifo #(.W(DATA_W + FCL_IDX_W)) u_fifo (
    .i_clk   (fcl_acc_clk),
    .i_rst_n (fcl_acc_rst_b),
    .i_clr   (fcl_acc_restart_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({w_relu, r_ncnt}),
    .o_dout  (w_dout),
    .o_empty (w_empty),
    .o_full  (w_full)
  );
endmodule

// File: tb/tb_fcl1_acc_relu.sv
// tb_fcl1_acc_relu: scenario tasks against an arithmetic reference of the MAC/shift/ReLU rules
module tb_fcl1_acc_relu;
  logic clk = 1'b0, rst_b = 1'b1, start = 1'b0, restart = 1'b0, rd_en = 1'b0, done, ovf;
  logic signed [7:0]  wt = '0, act = '0;
  logic signed [15:0] bias = '0;
  int checks = 0, failures = 0;
  int tw [5];
  int ta [5];
  int tb_b;
  bit mon_en = 1'b0;
  int done_cnt = 0;
  int got_d [$];
  int got_i [$];
  fcl1_acc_relu_if #(.DATA_W(8)) oif ();
  fcl1_acc_relu dut (
    .fcl_acc_clk          (clk),
    .fcl_acc_rst_b        (rst_b),
    .fcl_acc_start_i      (start),
    .fcl_acc_restart_i    (restart),
    .fcl_acc_sram_rd_en_i (rd_en),
    .fcl_acc_wt_i         (wt),
    .fcl_acc_act_i        (act),
    .fcl_acc_bias_i       (bias),
    .out_if               (oif.master),
    .fcl_acc_done_o       (done),
    .fcl_acc_ovf_o        (ovf)
  );
  always #5 clk = ~clk;
  // handshake/done monitor sampled mid-cycle
  always @(negedge clk) if (mon_en) begin
    if (oif.fcl_acc_out_valid_o && oif.fcl_acc_out_ready_i) begin
      got_d.push_back(int'(oif.fcl_acc_out_data_o));
      got_i.push_back(int'(oif.fcl_acc_out_idx_o));
    end
    if (done) done_cnt++;
  end
  function automatic int model();
    int s = tb_b;
    for (int k = 0; k < 5; k++) s += tw[k] * ta[k];
    s = s >>> 4;
    return s < 0 ? 0 : (s > 127 ? 127 : s);
  endfunction
  function automatic void rnd_neuron();
    for (int k = 0; k < 5; k++) begin
      tw[k] = int'($urandom_range(0, 255)) - 128;
      ta[k] = int'($urandom_range(0, 255)) - 128;
    end
    tb_b = int'($urandom_range(0, 65535)) - 32768;
  endfunction
  function automatic void set_neuron(int b, int w, int a);
    for (int k = 0; k < 5; k++) begin
      tw[k] = w;
      ta[k] = a;
    end
    tb_b = b;
  endfunction
  task automatic feed(input int nw, input bit pop_last);
    for (int i = 0; i <= nw; i++) begin
      @(posedge clk); #1;
      rd_en = (i < nw);
      if (i > 0) begin
        wt = 8'(tw[i-1]);
        act = 8'(ta[i-1]);
        bias = 16'(tb_b);
      end
      if (i == nw && pop_last) oif.fcl_acc_out_ready_i = 1'b1;
    end
  endtask
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask
  task automatic pulse_restart();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
  endtask
  task automatic test_reset();
    #2 rst_b = 1'b0;
    #3;
    checks++;
    if ({oif.fcl_acc_out_valid_o, oif.fcl_acc_out_data_o, oif.fcl_acc_out_idx_o, done, ovf} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b data=%0d idx=%0d done=%b ovf=%b want all 0",
               oif.fcl_acc_out_valid_o, oif.fcl_acc_out_data_o, oif.fcl_acc_out_idx_o, done, ovf);
    end
    #17 rst_b = 1'b1;
  endtask
  task automatic test_inert();
    set_neuron(100, 50, 50);
    feed(5, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (oif.fcl_acc_out_valid_o !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL inert_no_start got valid=%b done=%b want 0 0", oif.fcl_acc_out_valid_o, done);
    end
  endtask
  task automatic test_single(input string nm, input int b, input int w, input int a, input int want);
    pulse_restart();
    pulse_start();
    set_neuron(b, w, a);
    checks++;
    if (model() != want) begin
      failures++;
      $display("FAIL %s_model got %0d want %0d", nm, model(), want);
    end
    feed(5, 0);
    checks++;
    if (oif.fcl_acc_out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_early_valid got %b want 0", nm, oif.fcl_acc_out_valid_o);
    end
    @(posedge clk); #1;
    checks++;
    if (oif.fcl_acc_out_valid_o !== 1'b1 || oif.fcl_acc_out_data_o !== 8'(want) || oif.fcl_acc_out_idx_o !== 7'd0) begin
      failures++;
      $display("FAIL %s_result got valid=%b data=%0d idx=%0d want 1 %0d 0", nm,
               oif.fcl_acc_out_valid_o, oif.fcl_acc_out_data_o, oif.fcl_acc_out_idx_o, want);
    end
  endtask
  task automatic test_backpressure();
    int e [3];
    pulse_restart();
    pulse_start();
    oif.fcl_acc_out_ready_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      rnd_neuron();
      e[n] = model();
      feed(5, 0);
      @(posedge clk); #1;
      checks++;
      if (oif.fcl_acc_out_valid_o !== 1'b1 || oif.fcl_acc_out_data_o !== 8'(e[0]) || oif.fcl_acc_out_idx_o !== 7'd0) begin
        failures++;
        $display("FAIL bp_head_hold n=%0d got valid=%b data=%0d idx=%0d want 1 %0d 0", n,
                 oif.fcl_acc_out_valid_o, oif.fcl_acc_out_data_o, oif.fcl_acc_out_idx_o, e[0]);
      end
      checks++;
      if (ovf !== (n == 2)) begin
        failures++;
        $display("FAIL bp_ovf n=%0d got %b want %b", n, ovf, n == 2);
      end
    end
    oif.fcl_acc_out_ready_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (oif.fcl_acc_out_valid_o !== 1'b1 || oif.fcl_acc_out_data_o !== 8'(e[1]) || oif.fcl_acc_out_idx_o !== 7'd1) begin
      failures++;
      $display("FAIL bp_second got valid=%b data=%0d idx=%0d want 1 %0d 1",
               oif.fcl_acc_out_valid_o, oif.fcl_acc_out_data_o, oif.fcl_acc_out_idx_o, e[1]);
    end
    @(posedge clk); #1;
    checks++;
    if (oif.fcl_acc_out_valid_o !== 1'b0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL bp_drained got valid=%b ovf=%b want 0 1 (third dropped, ovf sticky)", oif.fcl_acc_out_valid_o, ovf);
    end
    oif.fcl_acc_out_ready_i = 1'b0;
  endtask
  task automatic test_full_with_pop();
    int e [3];
    pulse_restart();
    pulse_start();
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL fwp_start_clears_ovf got %b want 0", ovf);
    end
    oif.fcl_acc_out_ready_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      rnd_neuron();
      e[n] = model();
      feed(5, n == 2);
    end
    @(posedge clk); #1;
    checks++;
    if (ovf !== 1'b0 || oif.fcl_acc_out_valid_o !== 1'b1 || oif.fcl_acc_out_data_o !== 8'(e[1]) || oif.fcl_acc_out_idx_o !== 7'd1) begin
      failures++;
      $display("FAIL fwp_after got ovf=%b valid=%b data=%0d idx=%0d want 0 1 %0d 1", ovf,
               oif.fcl_acc_out_valid_o, oif.fcl_acc_out_data_o, oif.fcl_acc_out_idx_o, e[1]);
    end
    @(posedge clk); #1;
    checks++;
    if (oif.fcl_acc_out_valid_o !== 1'b1 || oif.fcl_acc_out_data_o !== 8'(e[2]) || oif.fcl_acc_out_idx_o !== 7'd2) begin
      failures++;
      $display("FAIL fwp_third got valid=%b data=%0d idx=%0d want 1 %0d 2",
               oif.fcl_acc_out_valid_o, oif.fcl_acc_out_data_o, oif.fcl_acc_out_idx_o, e[2]);
    end
    @(posedge clk); #1;
    checks++;
    if (oif.fcl_acc_out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL fwp_empty got valid=%b want 0", oif.fcl_acc_out_valid_o);
    end
    oif.fcl_acc_out_ready_i = 1'b0;
  endtask
  task automatic test_restart();
    int e;
    pulse_restart();
    pulse_start();
    oif.fcl_acc_out_ready_i = 1'b1;
    for (int n = 0; n < 7; n++) begin
      rnd_neuron();
      feed(5, 0);
    end
    set_neuron(5000, 127, 127);
    feed(3, 0);
    @(posedge clk); #1;
    restart = 1'b1;
    start = 1'b1;
    rd_en = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    start = 1'b0;
    rd_en = 1'b0;
    set_neuron(5000, 127, 127);
    feed(5, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (oif.fcl_acc_out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL restart_overrides_start got valid=%b want 0", oif.fcl_acc_out_valid_o);
    end
    pulse_start();
    rnd_neuron();
    e = model();
    feed(5, 0);
    @(posedge clk); #1;
    checks++;
    if (oif.fcl_acc_out_valid_o !== 1'b1 || oif.fcl_acc_out_data_o !== 8'(e) || oif.fcl_acc_out_idx_o !== 7'd0) begin
      failures++;
      $display("FAIL restart_fresh got valid=%b data=%0d idx=%0d want 1 %0d 0",
               oif.fcl_acc_out_valid_o, oif.fcl_acc_out_data_o, oif.fcl_acc_out_idx_o, e);
    end
    oif.fcl_acc_out_ready_i = 1'b0;
  endtask
  task automatic test_full_pass();
    int exp_d [$];
    int budget;
    pulse_restart();
    got_d.delete();
    got_i.delete();
    done_cnt = 0;
    oif.fcl_acc_out_ready_i = 1'b1;
    mon_en = 1'b1;
    pulse_start();
    for (int n = 0; n < 120; n++) begin
      rnd_neuron();
      exp_d.push_back(model());
      feed(5, 0);
    end
    budget = 0;
    while (done_cnt == 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL pass_done_pulses got %0d want 1", done_cnt);
    end
    checks++;
    if (got_d.size() != 120) begin
      failures++;
      $display("FAIL pass_count got %0d want 120", got_d.size());
    end
    for (int n = 0; n < got_d.size() && n < 120; n++) begin
      checks++;
      if (got_d[n] != exp_d[n] || got_i[n] != n) begin
        failures++;
        $display("FAIL pass_result n=%0d got data=%0d idx=%0d want %0d %0d", n, got_d[n], got_i[n], exp_d[n], n);
      end
    end
    checks++;
    if (ovf !== 1'b0 || oif.fcl_acc_out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL pass_end got ovf=%b valid=%b want 0 0", ovf, oif.fcl_acc_out_valid_o);
    end
    oif.fcl_acc_out_ready_i = 1'b0;
  endtask
  task automatic test_async_reset();
    pulse_restart();
    pulse_start();
    oif.fcl_acc_out_ready_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      set_neuron(1000 + n, 1, 1);
      feed(5, 0);
    end
    set_neuron(20, 3, 3);
    feed(2, 0);
    checks++;
    if (oif.fcl_acc_out_valid_o !== 1'b1 || oif.fcl_acc_out_data_o !== 8'd62 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre got valid=%b data=%0d ovf=%b want 1 62 1",
               oif.fcl_acc_out_valid_o, oif.fcl_acc_out_data_o, ovf);
    end
    #3 rst_b = 1'b0;
    #1;
    checks++;
    if ({oif.fcl_acc_out_valid_o, oif.fcl_acc_out_data_o, oif.fcl_acc_out_idx_o, done, ovf} !== 18'd0) begin
      failures++;
      $display("FAIL areset_immediate got valid=%b data=%0d idx=%0d done=%b ovf=%b want all 0",
               oif.fcl_acc_out_valid_o, oif.fcl_acc_out_data_o, oif.fcl_acc_out_idx_o, done, ovf);
    end
    #2 rst_b = 1'b1;
    set_neuron(3000, 10, 10);
    feed(5, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (oif.fcl_acc_out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL areset_inert got valid=%b want 0", oif.fcl_acc_out_valid_o);
    end
  endtask
  initial begin
    oif.fcl_acc_out_ready_i = 1'b0;
    test_reset();
    test_inert();
    test_single("basic", 16, 2, 3, 2);
    test_single("relu", -100, 1, 1, 0);
    test_single("clamp", 0, 127, 127, 127);
    test_backpressure();
    test_full_with_pop();
    test_restart();
    test_full_pass();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fcl1_acc_relu.md
FCL1_ACC_RELU -- requirements
Module: fcl1_acc_relu

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed width of activation, weight and output data.
REQ-002 SHALL have parameter ACC_W, default 24, signed accumulator width.
REQ-003 SHALL have parameter WORDS_PER_NEURON, default 5, products summed per neuron.
REQ-004 SHALL have parameter NUM_NEURONS, default 120, neurons per layer pass.
REQ-005 SHALL have parameter SHIFT, default 4, right-shift applied before clamping.
REQ-006 SHALL have port fcl_acc_clk, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port fcl_acc_rst_b, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port fcl_acc_start_i, input, 1, single-cycle pulse; begins a layer pass.
REQ-009 SHALL have port fcl_acc_restart_i, input, 1, synchronous abort to IDLE.
REQ-010 SHALL have port fcl_acc_sram_rd_en_i, input, 1, SRAM read strobe from the fcl1 control stage; read data is valid one cycle later.
REQ-011 SHALL have port fcl_acc_wt_i, input, DATA_W, signed weight (SRAM read data).
REQ-012 SHALL have port fcl_acc_act_i, input, DATA_W, signed activation, aligned with fcl_acc_wt_i.
REQ-013 SHALL have port fcl_acc_bias_i, input, 2*DATA_W, signed bias; sampled with the first word of each neuron.
REQ-014 SHALL have ports fcl_acc_out_valid_o (output, 1), fcl_acc_out_ready_i (input, 1) and fcl_acc_out_data_o (output, DATA_W), the result valid/ready handshake.
REQ-015 SHALL have port fcl_acc_out_idx_o, output, 7, neuron index of the presented result.
REQ-016 SHALL have port fcl_acc_done_o, output, 1, single-cycle pass-complete pulse.
REQ-017 SHALL have port fcl_acc_ovf_o, output, 1, sticky result-FIFO overflow flag.

Function
REQ-018 SHALL form the internal sample strobe smp_v as fcl_acc_sram_rd_en_i delayed by one flop; wt and act are used only when smp_v=1.
REQ-019 SHALL implement FSM states IDLE, ACC, FLUSH, DONE: IDLE->ACC on start; ACC->FLUSH after the NUM_NEURONS-th result is pushed; FLUSH->DONE when the FIFO is empty; DONE->IDLE in the next cycle, with done_o=1 in DONE only.
REQ-020 SHALL ignore smp_v outside ACC, and ignore start outside IDLE.
REQ-021 SHALL keep word counter wcnt in 0..WORDS_PER_NEURON-1, incrementing on each smp_v in ACC and wrapping to 0 after the last word.
REQ-022 SHALL, on wcnt=0, load acc = sext(bias) + sext(wt*act); on other words, acc = acc + sext(wt*act); products are full 2*DATA_W signed.
REQ-023 SHALL, on the last word, compute r = (acc_next >>> SHIFT), then output 0 if r<0, 2^(DATA_W-1)-1 if r exceeds it, else r[DATA_W-1:0]; push {r, ncnt} into the FIFO in the same cycle (1-cycle latency from last sample to FIFO write).
REQ-024 SHALL keep neuron counter ncnt in 0..NUM_NEURONS-1, incrementing per push.
REQ-025 SHALL use a 2-entry result FIFO; out_valid_o = not empty; pop on valid&&ready; the head data/idx stay stable while valid&&!ready.
REQ-026 SHALL push and pop in the same cycle when full: the pop succeeds and the push is accepted, no overflow.
REQ-027 SHALL, on a push when full without a pop, drop the new result and set ovf_o until the next start or reset.
REQ-028 SHALL, on restart in any state, clear wcnt, ncnt, acc and the FIFO and enter IDLE next cycle; restart overrides a coincident start or smp_v.

Reset
REQ-029 SHALL asynchronously set, while fcl_acc_rst_b=0: FSM=IDLE, wcnt=0, ncnt=0, acc=0, FIFO empty, out_valid_o=0, out_data_o=0, out_idx_o=0, done_o=0, ovf_o=0, smp_v flop=0.
REQ-030 SHALL remain inert after reset release until a start pulse.

Structure
REQ-031 SHALL place the state enum, NUM_NEURONS, WORDS_PER_NEURON, DATA_W, ACC_W and SHIFT defaults in the shared package fcl1_pkg.
REQ-032 SHALL instantiate exactly one sub-module, fcl1_res_fifo (2-entry, parameterized width); the rest stays in the top.

Verification
REQ-033 SHALL test: bias=16, five samples wt=2, act=3 -> acc=46, out_data=2, idx=0, valid one cycle after the fifth sample.
REQ-034 SHALL test: bias=-100, wt=1, act=1 ×5 -> out_data=0 (ReLU).
REQ-035 SHALL test: bias=0, wt=127, act=127 ×5 -> out_data=127 (clamp).
REQ-036 SHALL test: a full 120-neuron pass with ready=1 -> 120 results, idx 0..119 in order, done_o pulses once, ovf_o=0.
REQ-037 SHALL test: ready=0 for three neuron completions -> first two held stable, third dropped, ovf_o=1; plus the full-with-pop case keeps ovf_o=0.
REQ-038 SHALL test: restart at wcnt=3 of neuron 7, then start -> next result has idx=0 and no stale accumulation; async reset mid-ACC -> all outputs 0 immediately.
